// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-side line buffer.
package fetch_pkg;

    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LINE_W     = 8 * LINE_BYTES;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;
    localparam int unsigned WORD_IDX_W = $clog2(LINE_BYTES / WORD_BYTES);

    // Line tag is the address above the line offset: addr[31:TAG_LSB].
    localparam int unsigned TAG_LSB = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W   = 32 - TAG_LSB;

    typedef enum logic {
        FILL,
        READY
    } fetch_state_t;

endpackage

// File: rtl/line_word_select.sv
// Picks one 32-bit word out of a 128-bit line and restores big-endian byte order.
module line_word_select
    import fetch_pkg::*;
(
    input  logic [LINE_W-1:0]     line_i,
    input  logic [WORD_IDX_W-1:0] word_idx_i,
    output logic [WORD_W-1:0]     word_o
);

    logic [WORD_W-1:0] raw;

    always_comb begin
        raw    = line_i[WORD_W*word_idx_i +: WORD_W];
        // Lowest-addressed byte of the word becomes its most significant byte.
        word_o = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
    end

endmodule

// File: rtl/fetch_line_buffer.sv
// One-line instruction fetch buffer: fills a 16-byte line after a fixed memory latency
// and issues 32-bit instructions to decode over valid/ready, with branch redirect.
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FILL_LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       pc_in,
    input  logic              pc_load,
    output logic [31:0]       mem_address,
    input  logic [LINE_W-1:0] line_in,
    output logic [31:0]       instr_out,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int unsigned CntW    = $clog2(FILL_LATENCY + 1) + 1;
    localparam logic [31:0] ResetPc = {RESET_PC[31:2], 2'b00};

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       mem_address_q, mem_address_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              line_valid_q, line_valid_d;

    logic [31:0]       pc_inc;
    logic [WORD_W-1:0] word;
    logic              unused_pc_in_bits;

    assign unused_pc_in_bits = ^pc_in[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_address_d = mem_address_q;
        cnt_d         = cnt_q;
        line_d        = line_q;
        tag_d         = tag_q;
        line_valid_d  = line_valid_q;
        pc_inc        = pc_q + 32'd4;

        if (pc_load) begin
            // Redirect wins over any handshake this cycle.
            pc_d = {pc_in[31:2], 2'b00};
            if (line_valid_q && (pc_in[31:TAG_LSB] == tag_q)) begin
                state_d = READY;
            end else begin
                state_d       = FILL;
                mem_address_d = {pc_in[31:TAG_LSB], {TAG_LSB{1'b0}}};
                cnt_d         = '0;
            end
        end else begin
            unique case (state_q)
                FILL: begin
                    if (cnt_q == CntW'(FILL_LATENCY)) begin
                        line_d       = line_in;
                        tag_d        = pc_q[31:TAG_LSB];
                        line_valid_d = 1'b1;
                        state_d      = READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (instr_ready) begin
                        pc_d = pc_inc;
                        if (pc_q[3:2] == 2'b11) begin
                            state_d       = FILL;
                            mem_address_d = {pc_inc[31:TAG_LSB], {TAG_LSB{1'b0}}};
                            cnt_d         = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FILL;
            pc_q          <= ResetPc;
            mem_address_q <= {ResetPc[31:TAG_LSB], {TAG_LSB{1'b0}}};
            cnt_q         <= '0;
            line_q        <= '0;
            tag_q         <= '0;
            line_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_address_q <= mem_address_d;
            cnt_q         <= cnt_d;
            line_q        <= line_d;
            tag_q         <= tag_d;
            line_valid_q  <= line_valid_d;
        end
    end

    line_word_select u_word_select (
        .line_i     (line_q),
        .word_idx_i (pc_q[3:2]),
        .word_o     (word)
    );

    assign instr_valid = (state_q == READY);
    assign instr_out   = instr_valid ? word : '0;
    assign instr_pc    = pc_q;
    assign mem_address = mem_address_q;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: issued instructions go through a scoreboard,
// latencies and held outputs are checked inline.
module tb_fetch_line_buffer;

    localparam int unsigned FillLat = 5;

    logic         clock;
    logic         reset_n;
    logic [31:0]  pc_in;
    logic         pc_load;
    logic [31:0]  mem_address;
    logic [127:0] line_in;
    logic [31:0]  instr_out;
    logic [31:0]  instr_pc;
    logic         instr_valid;
    logic         instr_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    fetch_line_buffer #(
        .RESET_PC     (32'h0000_0000),
        .FILL_LATENCY (FillLat)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_load     (pc_load),
        .mem_address (mem_address),
        .line_in     (line_in),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents, byte k of a line at bits [8k+7:8k].
    function automatic logic [127:0] line_for(input logic [31:0] a);
        case (a)
            32'h00: return 128'h03506c01_02380901_0120a600_00084300;
            32'h10: return 128'h07989802_06885502_05781202_0468cf01;
            32'h20: return 128'h2c0000a3_280000a2_240000a1_200000a0;
            32'h30: return 128'h3c0000b3_380000b2_340000b1_300000b0;
            default: return {16{8'hee}};
        endcase
    endfunction

    // Memory model: line_in is garbage until FillLat edges after an address change.
    logic [31:0] last_addr;
    int          age;

    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_addr <= mem_address;
            age       <= 0;
        end else if (mem_address != last_addr) begin
            last_addr <= mem_address;
            age       <= 0;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    assign line_in = (age >= int'(FillLat)) ? line_for(mem_address) : {4{32'hbad0_bad0}};

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n && instr_valid && instr_ready && !pc_load) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got pc=%h instr=%h, expected nothing",
                         instr_pc, instr_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("issue_pc", instr_pc, e.pc);
                check32("issue_instr", instr_out, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        pc_in   = target;
        pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp_n);
        int n = 0;
        while (!instr_valid && n < 40) begin
            tick();
            n++;
        end
        check32(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        pc_in       = '0;
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        repeat (3) tick();
        check32("rst_valid", 32'(instr_valid), 32'd0);
        check32("rst_instr", instr_out, 32'h0);
        check32("rst_pc", instr_pc, 32'h0);
        check32("rst_addr", mem_address, 32'h0);

        // Reset fetch, sequential issue, then line crossing.
        push(32'h00, 32'h00430800);
        push(32'h04, 32'h00a62001);
        push(32'h08, 32'h01093802);
        push(32'h0c, 32'h016c5003);
        push(32'h10, 32'h01cf6804);
        instr_ready = 1'b1;
        @(negedge clock);
        #1 reset_n = 1'b1;
        wait_valid("reset_latency", 6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("seq_valid", 32'(instr_valid), 32'd1);
        end
        tick();
        check32("cross_addr", mem_address, 32'h10);
        check32("cross_valid", 32'(instr_valid), 32'd0);
        wait_valid("cross_latency", 6);
        check32("cross_pc", instr_pc, 32'h10);
        check32("cross_instr", instr_out, 32'h01cf6804);
        tick();
        instr_ready = 1'b0;

        // Miss back to line 0, then backpressure at 0x04.
        redirect(32'h04);
        wait_valid("miss_latency", 6);
        for (int i = 0; i < 3; i++) begin
            check32("bp_pc", instr_pc, 32'h04);
            check32("bp_instr", instr_out, 32'h00a62001);
            check32("bp_valid", 32'(instr_valid), 32'd1);
            tick();
        end

        // Redirect hit within the held line.
        redirect(32'h0b);
        check32("hit_valid", 32'(instr_valid), 32'd1);
        check32("hit_pc", instr_pc, 32'h08);
        check32("hit_instr", instr_out, 32'h01093802);
        check32("hit_addr", mem_address, 32'h00);

        // Redirects during fill: only the last target's line may be captured.
        redirect(32'h10);
        tick();
        redirect(32'h30);
        tick();
        tick();
        tick();
        redirect(32'h30);
        tick();
        redirect(32'h20);
        check32("midfill_addr", mem_address, 32'h20);
        check32("midfill_valid", 32'(instr_valid), 32'd0);
        wait_valid("midfill_latency", 6);
        check32("midfill_pc", instr_pc, 32'h20);
        check32("midfill_instr", instr_out, 32'ha0000020);

        // Redirect together with a handshake: the word at 0x04 is not consumed.
        redirect(32'h04);
        wait_valid("resteer_latency", 6);
        check32("resteer_pc", instr_pc, 32'h04);
        instr_ready = 1'b1;
        redirect(32'h30);
        instr_ready = 1'b0;
        wait_valid("simul_latency", 6);
        check32("simul_pc", instr_pc, 32'h30);
        check32("simul_instr", instr_out, 32'hb0000030);
        push(32'h30, 32'hb0000030);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check32("simul_advance", instr_pc, 32'h34);

        // PC wrap from the top of the address space.
        push(32'hffff_fffc, 32'heeeeeeee);
        push(32'h0000_0000, 32'h00430800);
        redirect(32'hffff_ffff);
        wait_valid("wrap_fill", 6);
        check32("wrap_top_pc", instr_pc, 32'hffff_fffc);
        instr_ready = 1'b1;
        tick();
        check32("wrap_addr", mem_address, 32'h0);
        wait_valid("wrap_latency", 6);
        check32("wrap_pc", instr_pc, 32'h0);
        tick();
        instr_ready = 1'b0;

        // Reset in the middle of a fill.
        redirect(32'h10);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check32("rst2_valid", 32'(instr_valid), 32'd0);
        check32("rst2_addr", mem_address, 32'h0);
        check32("rst2_pc", instr_pc, 32'h0);
        check32("rst2_instr", instr_out, 32'h0);
        tick();
        push(32'h00, 32'h00430800);
        instr_ready = 1'b1;
        @(negedge clock);
        #1 reset_n = 1'b1;
        wait_valid("rst2_latency", 6);
        tick();
        instr_ready = 1'b0;
        tick();

        check32("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
